// File: rtl/axs_pkg.sv
// Shared AXI4 slave definitions for the s0 port read and write FSMs.
// FSM state encodings, address map and response codes.
package axs_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_FETCH  = 4'b0010,
    ST_RVALID = 4'b0100,
    ST_ERR    = 4'b1000
  } axs_state_t;

  typedef enum logic [1:0] {
    SEL_VARINT = 2'd0,
    SEL_RAW    = 2'd1,
    SEL_STATUS = 2'd2,
    SEL_NONE   = 2'd3
  } axs_sel_t;

  localparam logic [7:0] ADDR_VARINT = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_RAW    = 8'hF0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic axs_sel_t axs_decode(
    input logic [7:0] addr
  );
    axs_sel_t sel;
    case (addr)
      ADDR_VARINT: sel = SEL_VARINT;
      ADDR_RAW:    sel = SEL_RAW;
      ADDR_STATUS: sel = SEL_STATUS;
      default:     sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/axs_read_fsm.sv
// AXI4 read-slave FSM for s0: returns encoder results from
// the varint/raw show-ahead FIFOs, plus a status word.
module axs_read_fsm
  import axs_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   axs_s0_arid,
  input  logic [ADDR_W-1:0] axs_s0_araddr,
  input  logic [7:0]        axs_s0_arlen,
  input  logic [2:0]        axs_s0_arsize,
  input  logic [1:0]        axs_s0_arburst,
  input  logic              axs_s0_arvalid,
  output logic              axs_s0_arready,
  output logic [ID_W-1:0]   axs_s0_rid,
  output logic [DATA_W-1:0] axs_s0_rdata,
  output logic [1:0]        axs_s0_rresp,
  output logic              axs_s0_rlast,
  output logic              axs_s0_rvalid,
  input  logic              axs_s0_rready,
  input  logic              varint_out_fifo_empty,
  input  logic [DATA_W-1:0] varint_out_fifo_q,
  output logic              varint_out_fifo_pop,
  input  logic              raw_data_out_fifo_empty,
  input  logic [DATA_W-1:0] raw_data_out_fifo_q,
  output logic              raw_data_out_fifo_pop
);

  axs_state_t        state;
  axs_state_t        state_n;
  axs_sel_t          sel;
  axs_sel_t          ar_sel;
  logic [7:0]        beats_left;
  logic              idle_c;
  logic              fetch_go;
  logic [DATA_W-1:0] fetch_data;
  logic [DATA_W-1:0] status_word;

  logic unused_ar;
  assign unused_ar = ^{axs_s0_arsize, axs_s0_arburst,
                       axs_s0_araddr[ADDR_W-1:8]};

  assign ar_sel = axs_decode(axs_s0_araddr[7:0]);

  assign status_word = {{(DATA_W-2){1'b0}},
                        raw_data_out_fifo_empty,
                        varint_out_fifo_empty};

  // Status beats never wait; data beats wait for a head word.
  always_comb begin
    fetch_go   = 1'b0;
    fetch_data = '0;
    unique case (sel)
      SEL_VARINT: begin
        fetch_go   = !varint_out_fifo_empty;
        fetch_data = varint_out_fifo_q;
      end
      SEL_RAW: begin
        fetch_go   = !raw_data_out_fifo_empty;
        fetch_data = raw_data_out_fifo_q;
      end
      SEL_STATUS: begin
        fetch_go   = 1'b1;
        fetch_data = status_word;
      end
      default: begin
        fetch_go   = 1'b0;
        fetch_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n               = state;
    idle_c                = 1'b0;
    varint_out_fifo_pop   = 1'b0;
    raw_data_out_fifo_pop = 1'b0;
    unique case (state)
      ST_IDLE: begin
        idle_c = 1'b1;
        if (axs_s0_arvalid) begin
          if (ar_sel == SEL_NONE) state_n = ST_ERR;
          else                    state_n = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fetch_go) begin
          varint_out_fifo_pop   = (sel == SEL_VARINT);
          raw_data_out_fifo_pop = (sel == SEL_RAW);
          state_n               = ST_RVALID;
        end
      end
      ST_RVALID: begin
        if (axs_s0_rready) begin
          if (beats_left == 8'd0) state_n = ST_IDLE;
          else                    state_n = ST_FETCH;
        end
      end
      ST_ERR: begin
        if (axs_s0_rready && beats_left == 8'd0)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign axs_s0_arready = idle_c & ~reset;
  assign axs_s0_rvalid  = (state == ST_RVALID) ||
                          (state == ST_ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      axs_s0_rid   <= '0;
      axs_s0_rdata <= '0;
      axs_s0_rresp <= RESP_OKAY;
      axs_s0_rlast <= 1'b0;
      sel          <= SEL_VARINT;
      beats_left   <= 8'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (axs_s0_arvalid) begin
            axs_s0_rid <= axs_s0_arid;
            sel        <= ar_sel;
            beats_left <= axs_s0_arlen;
            if (ar_sel == SEL_NONE) begin
              axs_s0_rdata <= '0;
              axs_s0_rresp <= RESP_SLVERR;
              axs_s0_rlast <= (axs_s0_arlen == 8'd0);
            end
          end
        end
        ST_FETCH: begin
          if (fetch_go) begin
            axs_s0_rdata <= fetch_data;
            axs_s0_rresp <= RESP_OKAY;
            axs_s0_rlast <= (beats_left == 8'd0);
          end
        end
        ST_RVALID: begin
          if (axs_s0_rready && beats_left != 8'd0)
            beats_left <= beats_left - 8'd1;
        end
        ST_ERR: begin
          if (axs_s0_rready && beats_left != 8'd0) begin
            beats_left   <= beats_left - 8'd1;
            axs_s0_rlast <= (beats_left == 8'd1);
          end
        end
        default: begin
          beats_left <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/axs_read_fsm.md
Name: axs_read_fsm

Overview:
- AXI4 read-slave control FSM. It is the return path for the encoder accelerator: the host reads results back over the AXI4 read channels.
- Each read beat to a data address pops one word from a show-ahead output FIFO (varint_out or raw_data_out) and returns it on the R channel.
- It sits beside the write-side FSM on the same AXI4 slave port, s0.
- It supports INCR bursts, a status address, and SLVERR for unmapped addresses.

Parameters:
- ID_W, 4, width of arid/rid.
- ADDR_W, 32, width of araddr.
- DATA_W, 32, width of rdata and of the FIFO data.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- axs_s0_arid  in  ID_W  read ID.
- axs_s0_araddr  in  ADDR_W  read address; only [7:0] is decoded.
- axs_s0_arlen  in  8  burst length minus 1.
- axs_s0_arsize  in  3  accepted and ignored; beats are always DATA_W.
- axs_s0_arburst  in  2  accepted; every burst is treated as FIXED address (same FIFO).
- axs_s0_arvalid  in  1  AR valid.
- axs_s0_arready  out  1  AR ready.
- axs_s0_rid  out  ID_W  echoes the latched arid.
- axs_s0_rdata  out  DATA_W  read data.
- axs_s0_rresp  out  2  00 = OKAY, 10 = SLVERR.
- axs_s0_rlast  out  1  final beat of the burst.
- axs_s0_rvalid  out  1  R valid.
- axs_s0_rready  in  1  R ready.
- varint_out_fifo_empty  in  1  varint result FIFO is empty.
- varint_out_fifo_q  in  DATA_W  head word of the varint FIFO (show-ahead).
- varint_out_fifo_pop  out  1  one-cycle pop strobe.
- raw_data_out_fifo_empty  in  1  raw FIFO is empty.
- raw_data_out_fifo_q  in  DATA_W  head word of the raw FIFO.
- raw_data_out_fifo_pop  out  1  one-cycle pop strobe.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All registered outputs clear to 0, and arready = 0 while reset is asserted.
  - Latched arid, address select and beat counter clear to 0.
- Address map, decoded from araddr[7:0] at AR acceptance:
  - 0x00: varint data (pop).
  - 0xF0: raw data (pop).
  - 0x08: status, no pop. rdata = {DATA_W-2 zeros, raw_data_out_fifo_empty, varint_out_fifo_empty}, sampled in the FETCH cycle.
  - Any other address: unmapped.
- State machine (one-hot):
  - IDLE:
    - arready = 1.
    - On arvalid: latch arid, the select, and beats_left = arlen.
    - Next state is FETCH for a mapped address, ERR for an unmapped one.
  - FETCH:
    - arready = 0.
    - If the selected FIFO is empty: stay in FETCH, rvalid = 0, no pop, no timeout.
    - Otherwise: capture q into rdata, assert the matching pop for exactly this cycle, set rresp = OKAY and rlast = (beats_left == 0), then go to RVALID.
    - Status beats never wait.
  - RVALID:
    - rvalid = 1.
    - rdata, rresp, rlast and rid are held stable until rready.
    - On rready: if beats_left == 0 go to IDLE; otherwise decrement beats_left and go to FETCH.
  - ERR:
    - rvalid = 1, rdata = 0, rresp = SLVERR, rlast = (beats_left == 0).
    - No pop.
    - On rready: decrement beats_left, or go to IDLE after the final beat.
- Latency:
  - AR handshake at cycle N.
  - FETCH at N+1 when the FIFO is non-empty.
  - rvalid high from N+2.
  - Sustained rate is one beat per 2 cycles.
- Pop rules:
  - Exactly one pop per OKAY data beat.
  - Never pop while the FIFO is empty.
  - Never pop in IDLE, RVALID or ERR.
- arready is low in every state except IDLE; a new AR is never accepted mid-burst.
- Reset mid-burst aborts the burst: remaining beats are dropped and FIFO contents are untouched.
- The beat counter is 8 bits; arlen = 255 gives 256 beats with no wrap.

Decomposition:
- Shared package (e.g. axs_pkg), also used by the write FSM:
  - State one-hot constants.
  - Address decode constants: ADDR_VARINT = 8'h00, ADDR_STATUS = 8'h08, ADDR_RAW = 8'hF0.
  - RESP_OKAY / RESP_SLVERR.
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- Varint FIFO holds 0xDEADBEEF; AR 0x00, arlen = 0, rready = 1 → one pop; rvalid at N+2 with rdata = 0xDEADBEEF, rresp = 00, rlast = 1, rid = arid.
- Raw FIFO holds 4 words; AR 0xF0, arlen = 3; rready toggles 1/0 → 4 pops, words returned in order, rlast only on beat 4, R payload stable while rready = 0.
- Varint FIFO empty; AR 0x00 → stays in FETCH with no pop and rvalid = 0; push 0x12345678 after 20 cycles → beat returned 2 cycles after empty deasserts.
- AR 0x44, arlen = 1 → two beats with rdata = 0, rresp = 10, rlast on the second; zero pops.
- AR 0x08 with varint empty and raw non-empty → rdata = 0x00000001, OKAY, no pop.
- Assert reset during RVALID of a 4-beat burst → rvalid drops immediately; after reset, IDLE with arready = 1 and FIFO occupancy unchanged.
